// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared block type and CBC sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int c_BLOCK_W = 128;

    typedef logic [c_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [2:0] {
        CBC_IDLE      = 3'd0,
        CBC_ISSUE     = 3'd1,
        CBC_WAIT_BUSY = 3'd2,
        CBC_WAIT_DONE = 3'd3,
        CBC_OUTPUT    = 3'd4
    } cbc_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_cbc.sv
// ============================================================================
// Module      : aes_cbc
// Description : CBC chaining wrapper around an external AES block core.
//               Optional block counter enabled by AES_CBC_BLOCK_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_cbc
    import aes_pkg::*;
#(
    parameter int DECIPHER = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] s_iv,
    input  logic         s_iv_load,
    input  logic [127:0] s_cbc_block,
    input  logic         s_cbc_valid,
    output logic         s_cbc_ready,
    output logic [127:0] m_cbc_block,
    output logic         m_cbc_valid,
    input  logic         m_cbc_ready,
    output logic [127:0] aes_block_out,
    output logic         aes_valid_out,
    input  logic         aes_ready_in,
`ifdef AES_CBC_BLOCK_COUNT_EN
    input  logic [127:0] aes_result_in,
    output logic [31:0]  m_cbc_count
`else
    input  logic [127:0] aes_result_in
`endif
);

    localparam bit c_DEC = (DECIPHER != 0);

    cbc_state_t r_state;
    cbc_state_t w_state_next;

    aes_block_t r_chain;
    aes_block_t r_next_chain;
    aes_block_t r_aes_block;
    aes_block_t r_m_block;
    logic       r_iv_ok;

    logic w_iv_take;
    logic w_accept;
    logic w_issue;
    logic w_done;
    logic w_out_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CBC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // IV load wins over a block accept when both arrive in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_iv_take    = 1'b0;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_out_hs     = 1'b0;
        case (r_state)
            CBC_IDLE: begin
                if (s_iv_load) begin
                    w_iv_take = 1'b1;
                end else if (s_cbc_valid && r_iv_ok) begin
                    w_accept     = 1'b1;
                    w_state_next = CBC_ISSUE;
                end
            end
            CBC_ISSUE: begin
                if (aes_ready_in) begin
                    w_issue      = 1'b1;
                    w_state_next = CBC_WAIT_BUSY;
                end
            end
            CBC_WAIT_BUSY: begin
                if (!aes_ready_in) begin
                    w_state_next = CBC_WAIT_DONE;
                end
            end
            CBC_WAIT_DONE: begin
                if (aes_ready_in) begin
                    w_done       = 1'b1;
                    w_state_next = CBC_OUTPUT;
                end
            end
            CBC_OUTPUT: begin
                if (m_cbc_ready) begin
                    w_out_hs     = 1'b1;
                    w_state_next = CBC_IDLE;
                end
            end
            default: w_state_next = CBC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iv_ok      <= 1'b0;
            r_chain      <= '0;
            r_next_chain <= '0;
            r_aes_block  <= '0;
            r_m_block    <= '0;
        end else begin
            if (w_iv_take) begin
                r_iv_ok <= 1'b1;
                r_chain <= s_iv;
            end
            if (w_accept) begin
                r_aes_block <= c_DEC ? s_cbc_block : (s_cbc_block ^ r_chain);
                if (c_DEC) begin
                    r_next_chain <= s_cbc_block;
                end
            end
            // Decipher chains on the stored ciphertext, encipher on the core result.
            if (w_done) begin
                r_m_block <= c_DEC ? (aes_result_in ^ r_chain) : aes_result_in;
                r_chain   <= c_DEC ? r_next_chain : aes_result_in;
            end
        end
    end

`ifdef AES_CBC_BLOCK_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_iv_take) begin
            r_count <= '0;
        end else if (w_out_hs) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign m_cbc_count = r_count;
`else
    logic w_count_unused;
    assign w_count_unused = w_out_hs;
`endif

    assign s_cbc_ready   = (r_state == CBC_IDLE) && r_iv_ok && !s_iv_load;
    assign aes_valid_out = w_issue;
    assign aes_block_out = r_aes_block;
    assign m_cbc_valid   = (r_state == CBC_OUTPUT);
    assign m_cbc_block   = r_m_block;

endmodule

`default_nettype wire

// File: doc/aes_cbc.md
AES_CBC -- requirements
Module: aes_cbc

Interface
REQ-001 SHALL have parameter DECIPHER, default 0; 0 selects CBC encipher chaining, 1 selects CBC decipher chaining.
REQ-002 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port s_iv, input, 128 bits, initialisation vector.
REQ-005 SHALL have port s_iv_load, input, 1 bit, one-cycle request to load s_iv into the chain register.
REQ-006 SHALL have port s_cbc_block, input, 128 bits, input block: plaintext for encipher, ciphertext for decipher.
REQ-007 SHALL have ports s_cbc_valid (input, 1 bit) and s_cbc_ready (output, 1 bit), the input handshake.
REQ-008 SHALL have port m_cbc_block, output, 128 bits, chained result block.
REQ-009 SHALL have ports m_cbc_valid (output, 1 bit) and m_cbc_ready (input, 1 bit), the output handshake.
REQ-010 SHALL have port aes_block_out, output, 128 bits, block sent to the AES core s_aes_block.
REQ-011 SHALL have port aes_valid_out, output, 1 bit, drives the AES core s_aes_valid.
REQ-012 SHALL have port aes_ready_in, input, 1 bit, from the AES core s_aes_ready.
REQ-013 SHALL have port aes_result_in, input, 128 bits, from the AES core m_aes_block.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and OUTPUT.
REQ-015 SHALL clear iv_ok on reset and set it when s_iv_load is sampled high in IDLE.
REQ-016 SHALL drive s_cbc_ready high only when state is IDLE, iv_ok is 1 and s_iv_load is 0.
REQ-017 SHALL ignore s_iv_load outside IDLE; in IDLE, an IV load takes precedence over a block accept in the same cycle.
REQ-018 SHALL, on an accept, register aes_block_out as s_cbc_block XOR chain when DECIPHER=0, or as s_cbc_block when DECIPHER=1.
REQ-019 SHALL, on an accept with DECIPHER=1, also capture s_cbc_block as next_chain, then enter ISSUE.
REQ-020 SHALL, in ISSUE, wait until aes_ready_in is 1, assert aes_valid_out for exactly one cycle, then enter WAIT_BUSY.
REQ-021 SHALL leave WAIT_BUSY for WAIT_DONE when aes_ready_in is 0.
REQ-022 SHALL leave WAIT_DONE when aes_ready_in is 1, registering m_cbc_block and entering OUTPUT.
REQ-023 SHALL compute m_cbc_block as aes_result_in when DECIPHER=0, or as aes_result_in XOR chain when DECIPHER=1.
REQ-024 SHALL update chain to aes_result_in when DECIPHER=0, or to next_chain when DECIPHER=1, at the same edge as REQ-022.
REQ-025 SHALL hold m_cbc_valid high and m_cbc_block stable in OUTPUT until m_cbc_ready is 1, then return to IDLE.
REQ-026 SHALL give minimum latency from accept edge to m_cbc_valid of core latency + 3 cycles, and accept the next block no earlier than the cycle after the output handshake.
REQ-027 SHALL consist entirely of 128-bit bitwise XOR; no arithmetic.

Reset
REQ-028 SHALL, on rst_n low at any time, including mid-operation, force state IDLE, iv_ok 0, chain and next_chain 0, aes_block_out 0, m_cbc_block 0, and aes_valid_out, m_cbc_valid and s_cbc_ready 0.
REQ-029 SHALL, after reset, let a still-busy core finish before re-issue; REQ-020 guarantees this.

Configuration
REQ-030 SHALL, with macro AES_CBC_BLOCK_COUNT_EN defined, add output m_cbc_count (32 bits, reset 0) that increments on each output handshake, wraps at 2^32-1 to 0, and clears on IV load.
REQ-031 SHALL, with AES_CBC_BLOCK_COUNT_EN undefined, omit that port and counter entirely.

Structure
REQ-032 SHALL place typedef aes_block_t (128-bit logic) and the cbc state enum in shared package aes_pkg.
REQ-033 SHALL instantiate no sub-module; the AES core stays external so the bench connects aes_enc (DECIPHER=0) or aes_dec (DECIPHER=1).

Verification (NIST SP800-38A CBC, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f)
REQ-034 SHALL cover encipher with DECIPHER=0 and aes_enc: P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d, then P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
REQ-035 SHALL cover decipher with DECIPHER=1 and aes_dec: 7649abac8119b246cee98e9b12e9197d -> 6bc1bee22e409f96e93d7e117393172a, then 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51.
REQ-036 SHALL cover backpressure: m_cbc_ready held 0 for 20 cycles -> m_cbc_valid stays 1, m_cbc_block stable, s_cbc_ready stays 0.
REQ-037 SHALL cover no-IV and simultaneous events: s_cbc_valid=1 before any IV load -> s_cbc_ready=0; s_iv_load and s_cbc_valid high together in IDLE -> IV loaded and block not accepted.
REQ-038 SHALL cover reset mid-operation: rst_n low in WAIT_DONE -> all outputs 0, and a new IV+P1 afterwards gives 7649abac8119b246cee98e9b12e9197d.
REQ-039 SHALL cover AES_CBC_BLOCK_COUNT_EN: 2 blocks -> m_cbc_count=2; a following IV load -> m_cbc_count=0.
